resultado_tx: RTL and testbench



---
 rtl/resultado_tx.sv | 150 +++++++++++++++
 tb/tb_resultado_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/resultado_tx.sv
// UART-style transmitter for ALU results: sends the result byte, then a {6'b0, carry, zero} flags byte.
// Defining RESULTADO_TX_PARITY_EN inserts an even-parity bit after the data bits of each frame.
module resultado_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rdo,
    input  logic       carry,
    input  logic       zero,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef RESULTADO_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [1:0]       flags_q, flags_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             tx_q, tx_d;
    logic             accept;
    logic             bit_end;
`ifdef RESULTADO_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // ready is registered, so the handshake uses the flopped value to stay consistent with the port
    assign accept  = valid & ready_q;
    assign bit_end = (baud_q == BaudLast);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        flags_d  = flags_q;
        tx_d     = 1'b1;
        baud_d   = (state_q == StIdle || bit_end) ? '0 : baud_q + 1'b1;
`ifdef RESULTADO_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = rdo;
                    flags_d = {carry, zero};
                    idx_d   = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = StData;
`ifdef RESULTADO_TX_PARITY_EN
                    parity_d = 1'b0;
`endif
                end
            end
            StData: begin
                tx_d = shreg_q[0];
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef RESULTADO_TX_PARITY_EN
                    parity_d = parity_q ^ shreg_q[0];
                    if (bit_q == 3'd7) state_d = StParity;
`else
                    if (bit_q == 3'd7) state_d = StStop;
`endif
                end
            end
`ifdef RESULTADO_TX_PARITY_EN
            StParity: begin
                tx_d = parity_q;
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_end) begin
                    if (!idx_q) begin
                        shreg_d = {6'b0, flags_q};
                        idx_d   = 1'b1;
                        state_d = StStart;
                    end else begin
                        idx_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_q == StIdle) && !accept;
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            idx_q    <= 1'b0;
            shreg_q  <= '0;
            flags_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
`ifdef RESULTADO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            flags_q  <= flags_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            tx_q     <= tx_d;
`ifdef RESULTADO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_resultado_tx.sv
// Bench for resultado_tx: directed and random transactions checked against a frame-level model.
module tb_resultado_tx;

    localparam int unsigned C = 4;
`ifdef RESULTADO_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int TXN_CYCLES = 2 * FRAME_BITS * C;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rdo   = 8'h00;
    logic       carry = 1'b0;
    logic       zero  = 1'b0;
    logic       valid = 1'b0;
    logic       ready, busy, tx;

    int n_checks = 0;
    int n_pass   = 0;

    resultado_tx #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdo   (rdo),
        .carry (carry),
        .zero  (zero),
        .valid (valid),
        .ready (ready),
        .busy  (busy),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of the result is the i-th bit on the line: start, 8 data LSB-first, [parity], stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef RESULTADO_TX_PARITY_EN
        f[9]  = ^b;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    task automatic accept(input logic [7:0] r, input logic c, input logic z, input bit keep);
        rdo   = r;
        carry = c;
        zero  = z;
        valid = 1'b1;
        check("ready before accept", 32'(ready), 32'd1);
        tick();
        if (!keep) valid = 1'b0;
    endtask

    // Entered in the cycle right after the accepting edge; leaves in the cycle ready returns.
    task automatic expect_txn(input string tag, input logic [7:0] r, input logic c,
                              input logic z, input int poke);
        logic [10:0] exp_f [2];
        logic [10:0] got_f [2];
        int          bad;
        int          fr;
        int          bi;
        exp_f[0] = frame_of(r);
        exp_f[1] = frame_of({6'b0, c, z});
        got_f[0] = '1;
        got_f[1] = '1;
        bad      = 0;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " ready after accept"}, 32'(ready), 32'd0);
        check({tag, " tx idle after accept"}, 32'(tx), 32'd1);
        for (int j = 0; j < TXN_CYCLES; j++) begin
            if (j == poke) begin
                rdo   = 8'hFF;
                valid = 1'b1;
            end
            if (j == poke + 1) valid = 1'b0;
            tick();
            fr = j / (FRAME_BITS * C);
            bi = (j % (FRAME_BITS * C)) / C;
            if (j % C == 0) got_f[fr][bi] = tx;
            if (tx !== exp_f[fr][bi] || busy !== 1'b1 || ready !== 1'b0) bad++;
        end
        check({tag, " frame result"}, 32'(got_f[0]), 32'(exp_f[0]));
        check({tag, " frame flags"}, 32'(got_f[1]), 32'(exp_f[1]));
        check({tag, " cycle-accurate line"}, 32'(bad), 32'd0);
        tick();
        check({tag, " ready returns"}, 32'(ready), 32'd1);
        check({tag, " busy clears"}, 32'(busy), 32'd0);
        check({tag, " tx idle at end"}, 32'(tx), 32'd1);
    endtask

    initial begin
        logic [7:0] r;
        logic       c;
        logic       z;
        int         bad;

        // Reset held for three cycles, then released
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset tx", 32'(tx), 32'd1);
            check("reset ready", 32'(ready), 32'd1);
            check("reset busy", 32'(busy), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        tick();
        check("post-reset tx", 32'(tx), 32'd1);
        check("post-reset ready", 32'(ready), 32'd1);
        check("post-reset busy", 32'(busy), 32'd0);

        accept(8'hA5, 1'b1, 1'b0, 1'b0);
        expect_txn("basic", 8'hA5, 1'b1, 1'b0, -10);

        // A request while busy must be ignored and later input changes must not leak in
        tick();
        accept(8'hA5, 1'b1, 1'b0, 1'b0);
        expect_txn("reject", 8'hA5, 1'b1, 1'b0, 3 * C);
        bad = 0;
        for (int i = 0; i < 3 * C; i++) begin
            tick();
            if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no queued txn", 32'(bad), 32'd0);

        // Held valid: second acceptance on the first cycle ready is back
        accept(8'h00, 1'b0, 1'b1, 1'b1);
        expect_txn("held 1", 8'h00, 1'b0, 1'b1, -10);
        tick();
        valid = 1'b0;
        expect_txn("held 2", 8'h00, 1'b0, 1'b1, -10);

        // Reset during data bit 3 of the first frame
        tick();
        accept(8'hA5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4 * C + 2; i++) tick();
        r = 8'hA5;
        check("mid-frame data bit 3", 32'(tx), 32'(r[3]));
        check("mid-frame busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset tx", 32'(tx), 32'd1);
        check("async reset ready", 32'(ready), 32'd1);
        check("async reset busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        accept(8'h3C, 1'b0, 1'b0, 1'b0);
        expect_txn("after reset", 8'h3C, 1'b0, 1'b0, -10);

        for (int k = 0; k < 4; k++) begin
            r = 8'($urandom);
            c = 1'($urandom);
            z = 1'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
            accept(r, c, z, 1'b0);
            expect_txn("random", r, c, z, -10);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
